// File: rtl/fusion_buffer_if.sv
// rtl/fusion_buffer_if.sv - scoreboard entry type and decode/issue handshake bundle for fusion_buffer
package fusion_buffer_pkg;
    typedef enum logic [3:0] {
        OP_ADD, OP_ADDW, OP_SUB, OP_LD, OP_LW, OP_LWU,
        OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SD, OP_OTHER
    } fu_op_t;

    typedef struct packed {
        logic valid;
    } exception_t;

    typedef struct packed {
        fu_op_t      op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use_imm;
        logic        use_pc;
        logic        is_compressed;
        logic [63:0] result;
        exception_t  ex;
        logic [1:0]  is_fusion;
    } scoreboard_entry_t;
endpackage

interface fusion_buffer_if #(
    parameter int unsigned NrInPorts  = 3,
    parameter int unsigned NrOutPorts = 2
);
    fusion_buffer_pkg::scoreboard_entry_t [NrInPorts-1:0]  decoded;
    logic [NrInPorts-1:0]                                  decoded_valid;
    logic                                                  decoded_ack;
    fusion_buffer_pkg::scoreboard_entry_t [NrOutPorts-1:0] issue_instr;
    logic [NrOutPorts-1:0]                                 issue_valid;
    logic [NrOutPorts-1:0]                                 issue_ack;
    logic [NrOutPorts-1:0]                                 fusion_event;

    modport master (
        output decoded, decoded_valid, issue_ack,
        input  decoded_ack, issue_instr, issue_valid, fusion_event
    );
    modport slave (
        input  decoded, decoded_valid, issue_ack,
        output decoded_ack, issue_instr, issue_valid, fusion_event
    );
endinterface

// File: rtl/fusion_buffer.sv
// rtl/fusion_buffer.sv - circular decode queue that greedily fuses ADD->LOAD and ADDI->ADDI pairs onto issue ports
module fusion_buffer
    import fusion_buffer_pkg::*;
#(
    parameter int unsigned NrInPorts    = 3,
    parameter int unsigned NrOutPorts   = 2,
    parameter int unsigned Depth        = 4,
    parameter logic [1:0]  FusionEnMask = 2'b11,
    parameter int unsigned HoldCycles   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    fusion_buffer_if.slave           bus,
    output logic [$clog2(Depth):0]   occupancy_o
);
    localparam int unsigned AW = $clog2(Depth);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned HW = (HoldCycles > 0) ? $clog2(HoldCycles + 1) : 1;
    localparam logic [HW-1:0] HoldMax = HW'(HoldCycles);

    scoreboard_entry_t [Depth-1:0] mem_q, mem_d;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [CW-1:0] in_cnt, off, deq, step;
    logic enq_ok, held, fused;
    scoreboard_entry_t a, b;

    function automatic logic is_add(input fu_op_t op);
        return (op == OP_ADD) || (op == OP_ADDW);
    endfunction

    function automatic logic is_load(input fu_op_t op);
        return (op == OP_LD) || (op == OP_LW) || (op == OP_LWU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_producer(input scoreboard_entry_t e);
        return is_add(e.op) && (e.rd != 5'd0) && !e.ex.valid;
    endfunction

    function automatic logic fusable(input scoreboard_entry_t x, input scoreboard_entry_t y);
        logic add_load, addi_addi;
        add_load  = is_load(y.op) && FusionEnMask[0];
        addi_addi = is_add(y.op) && x.use_imm && y.use_imm && !y.use_pc && FusionEnMask[1];
        return is_producer(x) && (y.rs1 == x.rd) && (y.rd == x.rd) && !y.ex.valid &&
               (add_load || addi_addi);
    endfunction

    // The fused op keeps the consumer's opcode; the producer's sources and immediate fold in.
    function automatic scoreboard_entry_t fuse(input scoreboard_entry_t x, input scoreboard_entry_t y);
        scoreboard_entry_t f;
        logic signed [33:0] sum;
        logic [2:0] pc_off;
        f      = y;
        f.rs1  = x.rs1;
        f.rs2  = x.rs2;
        pc_off = 3'd0;
        if (x.use_imm && x.use_pc) begin
            f.use_pc = 1'b1;
            pc_off   = x.is_compressed ? 3'd2 : 3'd4;
        end
        sum = $signed({x.result[32], x.result[32:0]}) + $signed({y.result[32], y.result[32:0]})
            - $signed({31'd0, pc_off});
        if (x.use_imm) f.result = {{30{sum[33]}}, sum};
        case ({x.is_compressed, y.is_compressed})
            2'b11:   f.is_fusion = 2'b01;
            2'b00:   f.is_fusion = 2'b11;
            default: f.is_fusion = 2'b10;
        endcase
        return f;
    endfunction

    always_comb begin
        mem_d            = mem_q;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q;
        hold_d           = hold_q;
        bus.issue_instr  = '0;
        bus.issue_valid  = '0;
        bus.fusion_event = '0;
        in_cnt           = '0;
        off              = '0;
        deq              = '0;
        step             = '0;
        fused            = 1'b0;
        a                = '0;
        b                = '0;

        for (int i = 0; i < NrInPorts; i++) in_cnt += CW'(bus.decoded_valid[i]);
        // Credit comes only from start-of-cycle occupancy; same-cycle dequeues do not count.
        enq_ok          = !flush_i && ((CW'(Depth) - count_q) >= in_cnt);
        bus.decoded_ack = enq_ok;

        held = (count_q == CW'(1)) && is_producer(mem_q[head_q]) &&
               (FusionEnMask != 2'b00) && (hold_q < HoldMax);

        for (int k = 0; k < NrOutPorts; k++) begin
            if (!flush_i && !held && (off < count_q)) begin
                a = mem_q[head_q + AW'(off)];
                b = mem_q[head_q + AW'(off) + AW'(1)];
                fused = ((off + CW'(1)) < count_q) && fusable(a, b);
                step  = fused ? CW'(2) : CW'(1);
                bus.issue_instr[k] = fused ? fuse(a, b) : a;
                bus.issue_valid[k] = 1'b1;
                if (bus.issue_ack[k]) begin
                    deq += step;
                    bus.fusion_event[k] = fused;
                end
                off += step;
            end
        end

        for (int i = 0; i < NrInPorts; i++) begin
            if (enq_ok && bus.decoded_valid[i]) mem_d[tail_q + AW'(i)] = bus.decoded[i];
        end

        head_d  = head_q + AW'(deq);
        tail_d  = tail_q + (enq_ok ? AW'(in_cnt) : AW'(0));
        count_d = count_q - deq + (enq_ok ? in_cnt : CW'(0));

        if (deq != '0)  hold_d = '0;
        else if (held)  hold_d = hold_q + 1'b1;

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            hold_q  <= hold_d;
        end
    end

    assign occupancy_o = count_q;
endmodule

// File: tb/tb_fusion_buffer.sv
// tb/tb_fusion_buffer.sv - directed self-checking bench for fusion_buffer
module tb_fusion_buffer;
    import fusion_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic flush_nf = 1'b0;
    logic [2:0] occ, occ_nf;
    int errors = 0;
    int checks = 0;
    scoreboard_entry_t exp0, exp1;

    fusion_buffer_if #(.NrInPorts(3), .NrOutPorts(2)) bi ();
    fusion_buffer_if #(.NrInPorts(3), .NrOutPorts(2)) ni ();

    fusion_buffer #(.NrInPorts(3), .NrOutPorts(2), .Depth(4), .FusionEnMask(2'b11), .HoldCycles(1)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .bus(bi), .occupancy_o(occ)
    );
    fusion_buffer #(.NrInPorts(3), .NrOutPorts(2), .Depth(4), .FusionEnMask(2'b00), .HoldCycles(1)) dut_nf (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush_nf), .bus(ni), .occupancy_o(occ_nf)
    );

    always #5 clk = ~clk;

    function automatic scoreboard_entry_t mk(input fu_op_t op, input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [4:0] rd, input logic imm, input logic pc,
                                             input logic comp, input logic [63:0] res);
        scoreboard_entry_t e;
        e = '0;
        e.op = op; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
        e.use_imm = imm; e.use_pc = pc; e.is_compressed = comp; e.result = res;
        return e;
    endfunction

    task automatic idle();
        bi.decoded = '0; bi.decoded_valid = '0; bi.issue_ack = '0; flush = 1'b0;
        ni.decoded = '0; ni.decoded_valid = '0; ni.issue_ack = '0; flush_nf = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk); #1;
        checks++; if (bi.issue_valid !== 2'b00) begin errors++; $display("FAIL reset_issue_valid got %b want 00", bi.issue_valid); end
        checks++; if (bi.fusion_event !== 2'b00) begin errors++; $display("FAIL reset_fusion_event got %b want 00", bi.fusion_event); end
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occ); end
        checks++; if (bi.decoded_ack !== 1'b1) begin errors++; $display("FAIL reset_decoded_ack got %b want 1", bi.decoded_ack); end
        rst_n = 1'b1;
    endtask

    task automatic test_add_load();
        @(negedge clk);
        idle();
        bi.decoded[0] = mk(OP_ADD, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 64'd8);
        bi.decoded[1] = mk(OP_LW, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 64'd4);
        bi.decoded_valid = 3'b011;
        #1;
        checks++; if (bi.decoded_ack !== 1'b1) begin errors++; $display("FAIL addld_dec_ack got %b want 1", bi.decoded_ack); end
        @(negedge clk);
        bi.decoded_valid = '0; bi.issue_ack = 2'b11;
        #1;
        exp0 = mk(OP_LW, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 64'd12); exp0.is_fusion = 2'b11;
        checks++; if (occ !== 3'd2) begin errors++; $display("FAIL addld_occ_before got %0d want 2", occ); end
        checks++; if (bi.issue_valid !== 2'b01) begin errors++; $display("FAIL addld_issue_valid got %b want 01", bi.issue_valid); end
        checks++; if (bi.issue_instr[0] !== exp0) begin errors++; $display("FAIL addld_fused_entry got %h want %h", bi.issue_instr[0], exp0); end
        checks++; if (bi.fusion_event !== 2'b01) begin errors++; $display("FAIL addld_fusion_event got %b want 01", bi.fusion_event); end
        @(negedge clk); #1;
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL addld_occ_after got %0d want 0", occ); end
    endtask

    task automatic test_cross_group();
        @(negedge clk);
        idle();
        bi.decoded[0] = mk(OP_ADD, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 64'h1000);
        bi.decoded_valid = 3'b001; bi.issue_ack = 2'b11;
        @(negedge clk);
        bi.decoded[0] = mk(OP_ADD, 5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 64'h10);
        #1;
        checks++; if (bi.issue_valid !== 2'b00) begin errors++; $display("FAIL cross_held_valid got %b want 00", bi.issue_valid); end
        checks++; if (occ !== 3'd1) begin errors++; $display("FAIL cross_held_occ got %0d want 1", occ); end
        @(negedge clk);
        bi.decoded_valid = '0;
        #1;
        exp0 = mk(OP_ADD, 5'd0, 5'd0, 5'd6, 1'b1, 1'b1, 1'b1, 64'h100C); exp0.is_fusion = 2'b10;
        checks++; if (bi.issue_valid !== 2'b01) begin errors++; $display("FAIL cross_issue_valid got %b want 01", bi.issue_valid); end
        checks++; if (bi.issue_instr[0] !== exp0) begin errors++; $display("FAIL cross_fused_entry got %h want %h", bi.issue_instr[0], exp0); end
        checks++; if (bi.fusion_event !== 2'b01) begin errors++; $display("FAIL cross_fusion_event got %b want 01", bi.fusion_event); end
    endtask

    task automatic test_hold_timeout();
        @(negedge clk);
        idle();
        #1;
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL hold_occ_start got %0d want 0", occ); end
        bi.decoded[0] = mk(OP_ADD, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 64'd1);
        bi.decoded_valid = 3'b001; bi.issue_ack = 2'b11;
        @(negedge clk);
        bi.decoded_valid = '0;
        #1;
        checks++; if (bi.issue_valid !== 2'b00) begin errors++; $display("FAIL hold_first_cycle got %b want 00", bi.issue_valid); end
        @(negedge clk); #1;
        exp0 = mk(OP_ADD, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 64'd1);
        checks++; if (bi.issue_valid !== 2'b01) begin errors++; $display("FAIL hold_timeout_valid got %b want 01", bi.issue_valid); end
        checks++; if (bi.issue_instr[0] !== exp0) begin errors++; $display("FAIL hold_timeout_entry got %h want %h", bi.issue_instr[0], exp0); end
        checks++; if (bi.fusion_event !== 2'b00) begin errors++; $display("FAIL hold_timeout_event got %b want 00", bi.fusion_event); end
        @(negedge clk); #1;
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL hold_occ_end got %0d want 0", occ); end
    endtask

    task automatic test_full();
        @(negedge clk);
        idle();
        for (int i = 0; i < 3; i++) bi.decoded[i] = mk(OP_SUB, 5'd1, 5'd2, 5'(10 + i), 1'b0, 1'b0, 1'b0, 64'd0);
        bi.decoded_valid = 3'b111;
        @(negedge clk);
        bi.decoded_valid = 3'b011;
        #1;
        checks++; if (occ !== 3'd3) begin errors++; $display("FAIL full_occ3 got %0d want 3", occ); end
        checks++; if (bi.decoded_ack !== 1'b0) begin errors++; $display("FAIL full_two_refused got %b want 0", bi.decoded_ack); end
        @(negedge clk);
        bi.decoded_valid = 3'b001;
        #1;
        checks++; if (bi.decoded_ack !== 1'b1) begin errors++; $display("FAIL full_one_accepted got %b want 1", bi.decoded_ack); end
        @(negedge clk);
        bi.decoded_valid = '0;
        #1;
        exp1 = mk(OP_SUB, 5'd1, 5'd2, 5'd11, 1'b0, 1'b0, 1'b0, 64'd0);
        checks++; if (occ !== 3'd4) begin errors++; $display("FAIL full_occ4 got %0d want 4", occ); end
        checks++; if (bi.issue_valid !== 2'b11) begin errors++; $display("FAIL full_issue_valid got %b want 11", bi.issue_valid); end
        checks++; if (bi.issue_instr[1] !== exp1) begin errors++; $display("FAIL full_port1_entry got %h want %h", bi.issue_instr[1], exp1); end
        bi.issue_ack = 2'b11;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL full_drained got %0d want 0", occ); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        idle();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 3; i++) bi.decoded[i] = mk(OP_SUB, 5'd3, 5'd4, 5'(20 + i), 1'b0, 1'b0, 1'b0, 64'd0);
        bi.decoded_valid = 3'b111;
        @(negedge clk);
        bi.decoded_valid = '0; bi.issue_ack = 2'b11;
        @(negedge clk);
        @(negedge clk); #1;
        checks++; if (dut.head_q !== 2'd3) begin errors++; $display("FAIL wrap_head_start got %0d want 3", dut.head_q); end
        bi.decoded[0] = mk(OP_ADD, 5'd8, 5'd9, 5'd8, 1'b0, 1'b0, 1'b0, 64'd0);
        bi.decoded[1] = mk(OP_LD, 5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0, 64'd0);
        bi.decoded_valid = 3'b011;
        @(negedge clk);
        bi.decoded_valid = '0;
        #1;
        exp0 = mk(OP_LD, 5'd8, 5'd9, 5'd8, 1'b1, 1'b0, 1'b0, 64'd0); exp0.is_fusion = 2'b11;
        checks++; if (bi.issue_valid !== 2'b01) begin errors++; $display("FAIL wrap_issue_valid got %b want 01", bi.issue_valid); end
        checks++; if (bi.issue_instr[0] !== exp0) begin errors++; $display("FAIL wrap_fused_entry got %h want %h", bi.issue_instr[0], exp0); end
        @(negedge clk); #1;
        checks++; if (dut.head_q !== 2'd1) begin errors++; $display("FAIL wrap_head_end got %0d want 1", dut.head_q); end
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL wrap_occ_end got %0d want 0", occ); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        idle();
        bi.decoded[0] = mk(OP_ADD, 5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 64'd3);
        bi.decoded_valid = 3'b001;
        @(negedge clk);
        bi.decoded_valid = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) bi.decoded[i] = mk(OP_SUB, 5'd1, 5'd1, 5'd1, 1'b0, 1'b0, 1'b0, 64'd0);
        bi.decoded_valid = 3'b111; bi.issue_ack = 2'b11; flush = 1'b1;
        #1;
        checks++; if (bi.issue_valid !== 2'b00) begin errors++; $display("FAIL flush_issue_valid got %b want 00", bi.issue_valid); end
        checks++; if (bi.decoded_ack !== 1'b0) begin errors++; $display("FAIL flush_dec_ack got %b want 0", bi.decoded_ack); end
        checks++; if (bi.fusion_event !== 2'b00) begin errors++; $display("FAIL flush_fusion_event got %b want 00", bi.fusion_event); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (occ !== 3'd0) begin errors++; $display("FAIL flush_occ_after got %0d want 0", occ); end
        checks++; if (bi.issue_valid !== 2'b00) begin errors++; $display("FAIL flush_valid_after got %b want 00", bi.issue_valid); end
    endtask

    task automatic test_no_fusion_mask();
        @(negedge clk);
        idle();
        ni.decoded[0] = mk(OP_ADD, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 64'd8);
        ni.decoded[1] = mk(OP_LW, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 64'd4);
        ni.decoded_valid = 3'b011; ni.issue_ack = 2'b11;
        @(negedge clk);
        ni.decoded[0] = mk(OP_ADD, 5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 64'd1);
        ni.decoded_valid = 3'b001;
        #1;
        exp0 = mk(OP_ADD, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 64'd8);
        exp1 = mk(OP_LW, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 64'd4);
        checks++; if (ni.issue_valid !== 2'b11) begin errors++; $display("FAIL nofuse_issue_valid got %b want 11", ni.issue_valid); end
        checks++; if (ni.issue_instr[0] !== exp0) begin errors++; $display("FAIL nofuse_port0 got %h want %h", ni.issue_instr[0], exp0); end
        checks++; if (ni.issue_instr[1] !== exp1) begin errors++; $display("FAIL nofuse_port1 got %h want %h", ni.issue_instr[1], exp1); end
        checks++; if (ni.fusion_event !== 2'b00) begin errors++; $display("FAIL nofuse_event got %b want 00", ni.fusion_event); end
        @(negedge clk);
        ni.decoded_valid = '0;
        #1;
        checks++; if (ni.issue_valid !== 2'b01) begin errors++; $display("FAIL nofuse_lone_not_held got %b want 01", ni.issue_valid); end
        @(negedge clk); #1;
        checks++; if (occ_nf !== 3'd0) begin errors++; $display("FAIL nofuse_occ_end got %0d want 0", occ_nf); end
    endtask

    initial begin
        test_reset();
        test_add_load();
        test_cross_group();
        test_hold_timeout();
        test_full();
        test_wrap();
        test_flush();
        test_no_fusion_mask();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
